// File: rtl/toggle_rx_pkg.sv
// Shared definitions for the toggle-handshake receiver: FSM state encoding
// and default parameter values.
package toggle_rx_pkg;

  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned DEPTH_DEF       = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    WAIT_SPACE
  } rx_state_t;

endpackage

// File: rtl/tog_sync.sv
// Synchronizes an asynchronous request toggle and flags each level change
// as a single-cycle edge.
module tog_sync
  import toggle_rx_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic tog_edge
);

  logic [STAGES-1:0] sync;
  logic              hist;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      hist <= sync[STAGES-1];
    end
  end

  assign tog_edge = sync[STAGES-1] ^ hist;

endmodule

// File: rtl/toggle_rx.sv
// Toggle-handshake receiver: accepts words from an asynchronous sender,
// buffers them in a small FIFO and presents them on a valid/ready port.
module toggle_rx
  import toggle_rx_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_tog,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack_tog,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              ev_pulse,
  output logic [7:0]        ev_count,
  output logic              ovf
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = {1'b1, {PTR_W{1'b0}}};

  rx_state_t          state;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic               tog_edge;
  logic               push;
  logic               pop;
  logic               full;

  tog_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rstn    (rstn),
    .din     (req_tog),
    .tog_edge(tog_edge)
  );

  assign full      = (count == FULL_CNT);
  assign push      = (state == CAPTURE);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      ack_tog  <= 1'b0;
      ev_pulse <= 1'b0;
      ev_count <= '0;
      ovf      <= 1'b0;
    end else begin
      ev_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tog_edge) state <= full ? WAIT_SPACE : CAPTURE;
        end
        CAPTURE: begin
          ack_tog  <= ~ack_tog;
          ev_pulse <= 1'b1;
          ev_count <= ev_count + 8'd1;
          state    <= IDLE;
          if (tog_edge) ovf <= 1'b1;
        end
        WAIT_SPACE: begin
          // A pop on this edge frees a slot, so capture can follow immediately.
          if (!full || pop) state <= CAPTURE;
          if (tog_edge) ovf <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_data;
  end

endmodule

// File: tb/tb_toggle_rx.sv
// Scoreboard bench for toggle_rx: expected words queued as requests are
// driven, checked as the consumer side pops them.
module tb_toggle_rx;

  logic       clk;
  logic       rstn;
  logic       req_tog;
  logic [7:0] req_data;
  logic       ack_tog;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       ev_pulse;
  logic [7:0] ev_count;
  logic       ovf;

  int         total;
  int         bad;
  logic [7:0] sb [$];
  logic [7:0] exp_d;
  logic       tog;

  toggle_rx #(
    .DATA_W     (8),
    .DEPTH      (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_tog  (req_tog),
    .req_data (req_data),
    .ack_tog  (ack_tog),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .ev_pulse (ev_pulse),
    .ev_count (ev_count),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer-side scoreboard: whatever the DUT pops must be the oldest expected word.
  always @(negedge clk) begin
    #1;
    if (rstn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: popped %0h, expected nothing", out_data);
      end else begin
        exp_d = sb.pop_front();
        if (out_data !== exp_d) begin
          bad++;
          $display("FAIL sb_data: got %0h want %0h", out_data, exp_d);
        end
      end
    end
  end

  task automatic apply_reset(input int unsigned cycles);
    @(negedge clk);
    rstn      = 1'b0;
    tog       = 1'b0;
    req_tog   = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    repeat (cycles) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic drive_req(input logic [7:0] d);
    @(negedge clk);
    req_data = d;
    tog      = ~tog;
    req_tog  = tog;
    sb.push_back(d);
  endtask

  task automatic wait_ack(input string name, output int unsigned lat, output int unsigned pulses);
    lat    = 0;
    pulses = 0;
    while (ack_tog !== tog && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (ev_pulse === 1'b1) pulses++;
    end
    total++;
    if (ack_tog !== tog) begin
      bad++;
      $display("FAIL %s_ack_timeout: ack_tog=%b want %b after %0d cycles", name, ack_tog, tog, lat);
    end
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (out_valid === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain_timeout: out_valid=%b want 0", name, out_valid);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_sb_left: got %0d words want 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    apply_reset(3);
    #1;
    total++; if (ack_tog !== 1'b0)   begin bad++; $display("FAIL rst_ack: got %b want 0", ack_tog); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (ev_pulse !== 1'b0)  begin bad++; $display("FAIL rst_pulse: got %b want 0", ev_pulse); end
    total++; if (ev_count !== 8'd0)  begin bad++; $display("FAIL rst_count: got %0d want 0", ev_count); end
    total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL rst_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_single();
    int unsigned lat;
    int unsigned pulses;
    drive_req(8'hA5);
    wait_ack("single", lat, pulses);
    repeat (3) begin
      @(posedge clk); #1;
      if (ev_pulse === 1'b1) pulses++;
    end
    total++; if (lat != 4)          begin bad++; $display("FAIL single_latency: got %0d want 4", lat); end
    total++; if (pulses != 1)       begin bad++; $display("FAIL single_pulses: got %0d want 1", pulses); end
    total++; if (ev_count !== 8'd1) begin bad++; $display("FAIL single_count: got %0d want 1", ev_count); end
    total++; if (out_valid !== 1'b1 || out_data !== 8'hA5)
      begin bad++; $display("FAIL single_data: got v=%b d=%0h want v=1 d=a5", out_valid, out_data); end
    drain("single");
  endtask

  task automatic test_full();
    int unsigned lat;
    int unsigned pulses;
    logic prev_ack;
    for (int i = 1; i <= 4; i++) begin
      drive_req(8'(i));
      wait_ack("full_fill", lat, pulses);
    end
    prev_ack = ack_tog;
    drive_req(8'h05);
    repeat (12) @(negedge clk);
    #1;
    total++; if (ack_tog !== prev_ack) begin bad++; $display("FAIL full_hold_ack: got %b want %b", ack_tog, prev_ack); end
    total++; if (ev_count !== 8'd5)    begin bad++; $display("FAIL full_hold_count: got %0d want 5", ev_count); end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_ack("full_fifth", lat, pulses);
    total++; if (ev_count !== 8'd6) begin bad++; $display("FAIL full_count: got %0d want 6", ev_count); end
    total++; if (sb.size() != 4)    begin bad++; $display("FAIL full_pending: got %0d want 4", sb.size()); end
    drain("full");
  endtask

  task automatic test_back_to_back();
    int unsigned lat;
    int unsigned pulses;
    int unsigned n;
    apply_reset(2);
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive_req(8'(i * 7 + 3));
      wait_ack("b2b", lat, pulses);
    end
    n = 0;
    while (out_valid === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2;
    total++; if (ev_count !== 8'd44) begin bad++; $display("FAIL b2b_count: got %0d want 44", ev_count); end
    total++; if (sb.size() != 0)     begin bad++; $display("FAIL b2b_lost: got %0d left want 0", sb.size()); end
    total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_ovf();
    int unsigned changes;
    logic prev_ack;
    apply_reset(2);
    changes  = 0;
    prev_ack = ack_tog;
    @(negedge clk);
    req_data = 8'h5A;
    tog      = 1'b1;
    req_tog  = 1'b1;
    sb.push_back(8'h5A);
    @(negedge clk);
    req_tog = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ack_tog !== prev_ack) changes++;
      prev_ack = ack_tog;
    end
    total++; if (changes != 1)      begin bad++; $display("FAIL ovf_acks: got %0d want 1", changes); end
    total++; if (ovf !== 1'b1)      begin bad++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    total++; if (ev_count !== 8'd1) begin bad++; $display("FAIL ovf_count: got %0d want 1", ev_count); end
    drain("ovf");
    total++; if (ovf !== 1'b1)      begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_reset_mid();
    int unsigned lat;
    int unsigned pulses;
    apply_reset(2);
    for (int i = 0; i < 3; i++) begin
      drive_req(8'(8'h10 + i));
      wait_ack("mid_fill", lat, pulses);
    end
    drive_req(8'h13);
    apply_reset(1);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    total++; if (ack_tog !== 1'b0)   begin bad++; $display("FAIL mid_ack: got %b want 0", ack_tog); end
    total++; if (ev_count !== 8'd0)  begin bad++; $display("FAIL mid_count: got %0d want 0", ev_count); end
    drive_req(8'h3C);
    wait_ack("mid_fresh", lat, pulses);
    total++; if (lat != 4)          begin bad++; $display("FAIL mid_latency: got %0d want 4", lat); end
    total++; if (ev_count !== 8'd1) begin bad++; $display("FAIL mid_fresh_count: got %0d want 1", ev_count); end
    drain("mid");
  endtask

  task automatic test_empty_ready();
    int unsigned lat;
    int unsigned pulses;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL empty_valid: cycle %0d got %b want 0", i, out_valid); end
    end
    @(negedge clk);
    out_ready = 1'b0;
    drive_req(8'h77);
    wait_ack("empty", lat, pulses);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h77)
      begin bad++; $display("FAIL empty_head: got v=%b d=%0h want v=1 d=77", out_valid, out_data); end
    drain("empty");
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rstn      = 1'b0;
    req_tog   = 1'b0;
    req_data  = '0;
    out_ready = 1'b0;
    tog       = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_ovf();
    test_reset_mid();
    test_empty_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/toggle_rx.md
TOGGLE_RX -- requirements
Module: toggle_rx

Interface
REQ-001 Parameter DATA_W, default 8: width of the data word carried per request.
REQ-002 Parameter DEPTH, default 4: receive-buffer entries; SHALL be a power of two, at least 2.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer flops on req_tog; minimum 2.
REQ-004 clk  input  1  sole clock; every register SHALL update on its rising edge.
REQ-005 rstn  input  1  reset; synchronous, active-low.
REQ-006 req_tog  input  1  asynchronous request toggle from the sending domain; each level change is one request.
REQ-007 req_data  input  DATA_W  request word; held stable by the sender from a req_tog change until the matching ack_tog change.
REQ-008 ack_tog  output  1  acknowledge toggle; each level change accepts one request.
REQ-009 out_valid  output  1  out_data holds a buffered word.
REQ-010 out_ready  input  1  consumer accepts out_data when out_valid=1.
REQ-011 out_data  output  DATA_W  oldest buffered word.
REQ-012 ev_pulse  output  1  one-cycle pulse on each accepted request.
REQ-013 ev_count  output  8  accepted-request counter.
REQ-014 ovf  output  1  sticky protocol-violation flag.

Function
REQ-015 req_tog SHALL pass through SYNC_STAGES flops, then one history flop; edge = last sync stage XOR history flop.
REQ-016 FSM states SHALL be IDLE, CAPTURE and WAIT_SPACE; reset state is IDLE.
REQ-017 IDLE: on edge with count<DEPTH go to CAPTURE; on edge with count=DEPTH go to WAIT_SPACE.
REQ-018 CAPTURE (one cycle): push req_data, toggle ack_tog, pulse ev_pulse, increment ev_count, return to IDLE; all four effects SHALL occur on the same clock edge.
REQ-019 WAIT_SPACE: hold until count<DEPTH, then go to CAPTURE; ack_tog SHALL NOT change while waiting.
REQ-020 Latency: with count<DEPTH, ack_tog SHALL change SYNC_STAGES+2 rising edges after the first edge that samples the new req_tog level.
REQ-021 out_valid SHALL equal (count!=0); a pop occurs on out_valid and out_ready; out_data is the head entry, with no bubble between consecutive words.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-023 A pop in the cycle WAIT_SPACE observes count=DEPTH SHALL take effect, and the capture SHALL follow on the next cycle.
REQ-024 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-025 ev_count SHALL wrap from 255 to 0.
REQ-026 An edge detected in CAPTURE or WAIT_SPACE is a protocol violation: ovf SHALL set, the edge is dropped, and ovf holds until reset.
REQ-027 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 When rstn=0 at a rising edge, all registers clear: ack_tog=0, out_valid=0, ev_pulse=0, ev_count=0, ovf=0, sync/history flops=0, pointers and count=0, state=IDLE.
REQ-029 Reset mid-request SHALL discard pending and buffered words; the sender SHALL restart with req_tog=0.
REQ-030 Buffer storage SHALL NOT be reset; out_data is don't-care while out_valid=0.

Structure
REQ-031 Package toggle_rx_pkg SHALL hold the FSM state enum and the default values of DATA_W, DEPTH and SYNC_STAGES.
REQ-032 One sub-module, tog_sync, SHALL hold the synchronizer chain, history flop and edge output; the buffer and FSM stay inline.

Verification
REQ-033 Reset, then one toggle of req_tog with req_data=0xA5 -> ack_tog 0->1 exactly 4 edges later (SYNC_STAGES=2), one ev_pulse, ev_count=1, out_data=0xA5.
REQ-034 Five requests with out_ready=0, data 0x01..0x05 -> four acks, fifth held in WAIT_SPACE; one pop -> fifth captured; then drain order 0x02..0x05.
REQ-035 Continuous out_ready=1 with back-to-back handshakes for 300 requests -> no loss, ev_count=44 (300 mod 256), order preserved.
REQ-036 Two req_tog changes 1 cycle apart -> first accepted, ovf=1, ack_tog toggles once.
REQ-037 rstn=0 for one edge while 3 words are buffered and one request is pending -> out_valid=0, ack_tog=0, ev_count=0 on the next cycle; a fresh request then completes normally.
REQ-038 out_ready held at 1 while empty for 10 cycles -> count stays 0, no pop, pointers unchanged.
